memshare_ibram_remap_loader: RTL and testbench

- Write-side sequencer for the IB-RAM rank inside a memShare VN group.
- Accepts a valid/ready stream of IB-LUT words, one word per (column, row) location.
- Generates the remap write sequence on the rank's remap port: data vector, column-select vector, row-address vector and active-LOW `nRemap_en`.
- Sits between the IB-LUT update controller (per-iteration LUT reload) and every `memShare_vn_group` instance of a share group.

---
 rtl/memshare_ibram_remap_loader.sv | 116 +++++++++++
 tb/tb_memshare_ibram_remap_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/memshare_ibram_remap_loader.sv
// IB-RAM remap write sequencer: turns a stream of IB-LUT words into row-inner,
// column-outer remap writes replicated across every member of a share group.
module memshare_ibram_remap_loader #(
    parameter int QUAN_SIZE             = 4,
    parameter int SHARE_GROUP_SIZE      = 4,
    parameter int GP2_COL_SEL_WIDTH     = 3,
    parameter int ROW_ADDR_WIDTH        = 4,
    parameter int RANK_COL_ADDR_WIDTH   = GP2_COL_SEL_WIDTH * SHARE_GROUP_SIZE,
    parameter int IBRAM_REMAP_VEC_WIDTH = QUAN_SIZE * SHARE_GROUP_SIZE
) (
    input  logic                                       sys_clk,
    input  logic                                       rstn,
    input  logic                                       load_start_i,
    input  logic [GP2_COL_SEL_WIDTH-1:0]               col_base_i,
    input  logic [GP2_COL_SEL_WIDTH:0]                 col_count_i,
    input  logic                                       abort_i,
    input  logic [IBRAM_REMAP_VEC_WIDTH-1:0]           lut_word_i,
    input  logic                                       lut_valid_i,
    output logic                                       lut_ready_o,
    output logic [IBRAM_REMAP_VEC_WIDTH-1:0]           remap_dataIn_vec_o,
    output logic [RANK_COL_ADDR_WIDTH-1:0]             remap_colSel_vec_o,
    output logic [ROW_ADDR_WIDTH*SHARE_GROUP_SIZE-1:0] remap_rowAddr_vec_o,
    output logic                                       nRemap_en_o,
    output logic                                       busy_o,
    output logic                                       done_o
);

    localparam logic [ROW_ADDR_WIDTH-1:0]  ROW_LAST = '1;
    localparam logic [ROW_ADDR_WIDTH-1:0]  ROW_ONE  = 1;
    localparam logic [GP2_COL_SEL_WIDTH:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                          state;
    state_t                          state_next;
    logic [GP2_COL_SEL_WIDTH-1:0]    col_base_q;
    logic [GP2_COL_SEL_WIDTH:0]      col_count_q;
    logic [GP2_COL_SEL_WIDTH:0]      col_cnt;
    logic [ROW_ADDR_WIDTH-1:0]       row_cnt;
    logic [GP2_COL_SEL_WIDTH-1:0]    col_now;
    logic [IBRAM_REMAP_VEC_WIDTH-1:0] data_q;
    logic [GP2_COL_SEL_WIDTH-1:0]    col_q;
    logic [ROW_ADDR_WIDTH-1:0]       row_q;
    logic                            n_en_q;
    logic                            start_ok;
    logic                            accept;
    logic                            last_beat;

    assign lut_ready_o = (state == LOAD);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign start_ok    = (state == IDLE) && load_start_i && !abort_i;
    // An abort in LOAD swallows any beat presented in the same cycle.
    assign accept      = lut_ready_o && lut_valid_i && !abort_i;
    assign last_beat   = accept && (row_cnt == ROW_LAST) &&
                         ((col_cnt + CNT_ONE) == col_count_q);
    assign col_now     = col_base_q + col_cnt[GP2_COL_SEL_WIDTH-1:0];

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = (col_count_i == '0) ? DONE : LOAD;
            LOAD: begin
                if (abort_i)        state_next = IDLE;
                else if (last_beat) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            col_base_q  <= '0;
            col_count_q <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
        end else if (start_ok) begin
            col_base_q  <= col_base_i;
            col_count_q <= col_count_i;
            col_cnt     <= '0;
            row_cnt     <= '0;
        end else if (accept) begin
            row_cnt <= row_cnt + ROW_ONE;
            if (row_cnt == ROW_LAST) col_cnt <= col_cnt + CNT_ONE;
        end
    end

    // Write port is registered: one cycle from accepted beat to the write strobe.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            n_en_q <= 1'b1;
        end else begin
            n_en_q <= !accept;
            if (accept) begin
                data_q <= lut_word_i;
                col_q  <= col_now;
                row_q  <= row_cnt;
            end
        end
    end

    assign remap_dataIn_vec_o  = data_q;
    assign remap_colSel_vec_o  = {SHARE_GROUP_SIZE{col_q}};
    assign remap_rowAddr_vec_o = {SHARE_GROUP_SIZE{row_q}};
    assign nRemap_en_o         = n_en_q;

endmodule

// File: tb/tb_memshare_ibram_remap_loader.sv
// Directed self-checking bench for the IB-RAM remap loader, using expected
// write sequences computed by hand from the load parameters.
module tb_memshare_ibram_remap_loader;

    localparam int SG = 4;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        load_start_i = 1'b0;
    logic [2:0]  col_base_i = '0;
    logic [3:0]  col_count_i = '0;
    logic        abort_i = 1'b0;
    logic [15:0] lut_word_i = '0;
    logic        lut_valid_i = 1'b0;
    logic        lut_ready_o;
    logic [15:0] remap_dataIn_vec_o;
    logic [11:0] remap_colSel_vec_o;
    logic [15:0] remap_rowAddr_vec_o;
    logic        nRemap_en_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    memshare_ibram_remap_loader dut (
        .sys_clk            (sys_clk),
        .rstn               (rstn),
        .load_start_i       (load_start_i),
        .col_base_i         (col_base_i),
        .col_count_i        (col_count_i),
        .abort_i            (abort_i),
        .lut_word_i         (lut_word_i),
        .lut_valid_i        (lut_valid_i),
        .lut_ready_o        (lut_ready_o),
        .remap_dataIn_vec_o (remap_dataIn_vec_o),
        .remap_colSel_vec_o (remap_colSel_vec_o),
        .remap_rowAddr_vec_o(remap_rowAddr_vec_o),
        .nRemap_en_o        (nRemap_en_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, cross the clock edge, and settle 1 time unit after it.
    task automatic apply_stimulus(input logic start, input logic [2:0] base, input logic [3:0] count,
                                  input logic valid, input logic [15:0] word, input logic abort);
        load_start_i = start;
        col_base_i   = base;
        col_count_i  = count;
        lut_valid_i  = valid;
        lut_word_i   = word;
        abort_i      = abort;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [15:0] data, input logic [2:0] col,
                                input logic [3:0] row, input logic done_exp);
        logic [11:0] col_vec;
        logic [15:0] row_vec;
        col_vec = {SG{col}};
        row_vec = {SG{row}};
        check_output({tag, "_en"},   {31'd0, nRemap_en_o}, 32'd0);
        check_output({tag, "_data"}, {16'd0, remap_dataIn_vec_o}, {16'd0, data});
        check_output({tag, "_col"},  {20'd0, remap_colSel_vec_o}, {20'd0, col_vec});
        check_output({tag, "_row"},  {16'd0, remap_rowAddr_vec_o}, {16'd0, row_vec});
        check_output({tag, "_done"}, {31'd0, done_o}, {31'd0, done_exp});
    endtask

    task automatic expect_quiet(input string tag, input logic busy_exp, input logic ready_exp,
                                input logic done_exp);
        check_output({tag, "_en"},    {31'd0, nRemap_en_o}, 32'd1);
        check_output({tag, "_busy"},  {31'd0, busy_o},      {31'd0, busy_exp});
        check_output({tag, "_ready"}, {31'd0, lut_ready_o}, {31'd0, ready_exp});
        check_output({tag, "_done"},  {31'd0, done_o},      {31'd0, done_exp});
    endtask

    initial begin
        logic [2:0] col;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        expect_quiet("rst", 1'b0, 1'b0, 1'b0);
        check_output("rst_data", {16'd0, remap_dataIn_vec_o}, 32'd0);
        check_output("rst_col",  {20'd0, remap_colSel_vec_o}, 32'd0);
        check_output("rst_row",  {16'd0, remap_rowAddr_vec_o}, 32'd0);
        rstn = 1'b1;
        @(posedge sys_clk);
        #1;

        // Back-to-back single column at base 0
        $display("[TB] back-to-back load");
        apply_stimulus(1'b1, 3'd0, 4'd1, 1'b0, 16'h0000, 1'b0);
        expect_quiet("b2b_start", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 3'd0, 4'd0, 1'b1, 16'h1000 + 16'(i), 1'b0);
            expect_write("b2b", 16'h1000 + 16'(i), 3'd0, 4'(i), i == 15);
        end
        check_output("b2b_ready_in_done", {31'd0, lut_ready_o}, 32'd0);
        apply_stimulus(1'b0, 3'd0, 4'd0, 1'b0, 16'h0000, 1'b0);
        expect_quiet("b2b_end", 1'b0, 1'b0, 1'b0);
        check_output("b2b_hold", {16'd0, remap_dataIn_vec_o}, 32'h100F);

        // Column wrap 6,7,0 with a bubble after every beat
        $display("[TB] column wrap with throttling");
        apply_stimulus(1'b1, 3'd6, 4'd3, 1'b0, 16'h0000, 1'b0);
        for (int b = 0; b < 48; b++) begin
            col = 3'(6 + b / 16);
            apply_stimulus(1'b0, 3'd0, 4'd0, 1'b1, 16'h5000 + 16'(b), 1'b0);
            expect_write("wrap", 16'h5000 + 16'(b), col, 4'(b % 16), b == 47);
            if (b == 16) check_output("wrap_col7", {20'd0, remap_colSel_vec_o}, 32'hFFF);
            if (b < 47) begin
                apply_stimulus(1'b0, 3'd0, 4'd0, 1'b0, 16'hDEAD, 1'b0);
                expect_quiet("wrap_bubble", 1'b1, 1'b1, 1'b0);
                check_output("wrap_hold_data", {16'd0, remap_dataIn_vec_o}, {16'd0, 16'h5000 + 16'(b)});
                check_output("wrap_hold_row", {16'd0, remap_rowAddr_vec_o}, {16'd0, {SG{4'(b % 16)}}});
            end
        end
        apply_stimulus(1'b0, 3'd0, 4'd0, 1'b0, 16'h0000, 1'b0);
        expect_quiet("wrap_end", 1'b0, 1'b0, 1'b0);

        // Zero column count goes straight to DONE
        $display("[TB] zero count");
        apply_stimulus(1'b1, 3'd2, 4'd0, 1'b1, 16'h9999, 1'b0);
        expect_quiet("zero_done", 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 3'd0, 4'd0, 1'b1, 16'h9999, 1'b0);
        expect_quiet("zero_idle", 1'b0, 1'b0, 1'b0);

        // Abort on beat 20 of a two-column load, with a start in the same cycle
        $display("[TB] abort");
        apply_stimulus(1'b1, 3'd2, 4'd2, 1'b0, 16'h0000, 1'b0);
        for (int b = 0; b < 20; b++) begin
            apply_stimulus(1'b0, 3'd0, 4'd0, 1'b1, 16'h6000 + 16'(b), 1'b0);
            expect_write("abort_beat", 16'h6000 + 16'(b), 3'(2 + b / 16), 4'(b % 16), 1'b0);
        end
        apply_stimulus(1'b1, 3'd5, 4'd1, 1'b1, 16'hBEEF, 1'b1);
        expect_quiet("abort_cut", 1'b0, 1'b0, 1'b0);
        check_output("abort_hold", {16'd0, remap_dataIn_vec_o}, 32'h6013);
        apply_stimulus(1'b0, 3'd0, 4'd0, 1'b0, 16'h0000, 1'b0);
        expect_quiet("abort_after", 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd0, 4'd1, 1'b0, 16'h0000, 1'b1);
        expect_quiet("abort_vs_start", 1'b0, 1'b0, 1'b0);

        // Start while busy must not disturb the running load
        $display("[TB] start while busy");
        apply_stimulus(1'b1, 3'd0, 4'd1, 1'b0, 16'h0000, 1'b0);
        for (int b = 0; b < 16; b++) begin
            apply_stimulus(b == 5, 3'd3, 4'd2, 1'b1, 16'h7000 + 16'(b), 1'b0);
            expect_write("busy_start", 16'h7000 + 16'(b), 3'd0, 4'(b), b == 15);
        end
        apply_stimulus(1'b0, 3'd0, 4'd0, 1'b0, 16'h0000, 1'b0);
        expect_quiet("busy_end", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a load, then a clean reload
        $display("[TB] reset mid-load");
        apply_stimulus(1'b1, 3'd1, 4'd1, 1'b0, 16'h0000, 1'b0);
        for (int b = 0; b < 5; b++) begin
            apply_stimulus(1'b0, 3'd0, 4'd0, 1'b1, 16'h3000 + 16'(b), 1'b0);
            expect_write("mid_beat", 16'h3000 + 16'(b), 3'd1, 4'(b), 1'b0);
        end
        rstn = 1'b0;
        #1;
        expect_quiet("mid_rst", 1'b0, 1'b0, 1'b0);
        check_output("mid_rst_data", {16'd0, remap_dataIn_vec_o}, 32'd0);
        check_output("mid_rst_col",  {20'd0, remap_colSel_vec_o}, 32'd0);
        check_output("mid_rst_row",  {16'd0, remap_rowAddr_vec_o}, 32'd0);
        #1;
        rstn = 1'b1;
        apply_stimulus(1'b0, 3'd0, 4'd0, 1'b1, 16'h7777, 1'b0);
        expect_quiet("mid_after", 1'b0, 1'b0, 1'b0);
        check_output("mid_after_data", {16'd0, remap_dataIn_vec_o}, 32'd0);
        apply_stimulus(1'b1, 3'd4, 4'd1, 1'b0, 16'h0000, 1'b0);
        for (int b = 0; b < 16; b++) begin
            apply_stimulus(1'b0, 3'd0, 4'd0, 1'b1, 16'h4000 + 16'(b), 1'b0);
            expect_write("reload", 16'h4000 + 16'(b), 3'd4, 4'(b), b == 15);
        end
        apply_stimulus(1'b0, 3'd0, 4'd0, 1'b0, 16'h0000, 1'b0);
        expect_quiet("reload_end", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
